// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master round-robin arbiter with lock for the unified memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WADDR        = 32,
  parameter int WDATA        = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic             m0_lock,
  input  logic [WADDR-1:0] m0_addr,
  input  logic [2:0]       m0_size,
  input  logic [WDATA-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WDATA-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic             m1_lock,
  input  logic [WADDR-1:0] m1_addr,
  input  logic [2:0]       m1_size,
  input  logic [WDATA-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WDATA-1:0] m1_rdata,
  output logic             s_read,
  output logic             s_wren,
  output logic [WADDR-1:0] s_addr,
  output logic [2:0]       s_size,
  output logic [WDATA-1:0] s_wdata,
  input  logic [WDATA-1:0] s_rdata
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED0  = 2'd1,
    ST_LOCKED1  = 2'd2
  } state_t;

  localparam int            c_CW      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(LOCK_TIMEOUT);
  localparam bit            c_TO_EN   = (LOCK_TIMEOUT != 0);

  state_t          r_state, w_state_nxt;
  logic            r_last, w_last_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic            r_rd_pend, r_rd_owner;
  logic            w_g0, w_g1, w_timeout, w_owner_req;
  logic [c_CW-1:0] w_cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_UNLOCKED;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_pend  <= (w_g0 & ~m0_we) | (w_g1 & ~m1_we);
      r_rd_owner <= w_g1;
    end
  end

  always_comb begin
    w_g0        = 1'b0;
    w_g1        = 1'b0;
    w_timeout   = 1'b0;
    w_owner_req = 1'b0;
    w_cnt_nxt   = '0;
    w_cnt_inc   = r_cnt + c_CW'(1);
    w_state_nxt = r_state;
    w_last_nxt  = r_last;

    case (r_state)
      ST_UNLOCKED: begin
        // r_last names the previous winner; the other master wins a tie
        w_g0 = m0_req & (~m1_req | r_last);
        w_g1 = m1_req & (~m0_req | ~r_last);
      end
      ST_LOCKED0: begin
        w_g0        = m0_req;
        w_owner_req = m0_req;
      end
      ST_LOCKED1: begin
        w_g1        = m1_req;
        w_owner_req = m1_req;
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase

    // idle counter only runs while the lock owner is not requesting
    if (r_state != ST_UNLOCKED && !w_owner_req && c_TO_EN) begin
      if (w_cnt_inc == c_TIMEOUT) w_timeout = 1'b1;
      else                        w_cnt_nxt = w_cnt_inc;
    end

    if (rst) begin
      w_g0 = 1'b0;
      w_g1 = 1'b0;
    end

    if (w_g0) begin
      w_state_nxt = m0_lock ? ST_LOCKED0 : ST_UNLOCKED;
      w_last_nxt  = 1'b0;
    end else if (w_g1) begin
      w_state_nxt = m1_lock ? ST_LOCKED1 : ST_UNLOCKED;
      w_last_nxt  = 1'b1;
    end else if (w_timeout) begin
      w_state_nxt = ST_UNLOCKED;
    end
  end

  always_comb begin
    s_read  = 1'b0;
    s_wren  = 1'b0;
    s_addr  = '0;
    s_size  = '0;
    s_wdata = '0;
    if (w_g0) begin
      s_read  = ~m0_we;
      s_wren  = m0_we;
      s_addr  = m0_addr;
      s_size  = m0_size;
      s_wdata = m0_wdata;
    end else if (w_g1) begin
      s_read  = ~m1_we;
      s_wren  = m1_we;
      s_addr  = m1_addr;
      s_size  = m1_size;
      s_wdata = m1_wdata;
    end
  end

  assign m0_gnt    = w_g0;
  assign m1_gnt    = w_g1;
  assign m0_rvalid = r_rd_pend & ~r_rd_owner & ~rst;
  assign m1_rvalid = r_rd_pend & r_rd_owner & ~rst;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Vector-table bench for mem_arbiter with a 1-cycle slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [31:0] c_K   = 32'hA5A5_0000;
  localparam logic [2:0]  c_SZ0 = 3'd2;
  localparam logic [2:0]  c_SZ1 = 3'd5;
  localparam logic [31:0] c_WD0 = 32'h1234_5678;
  localparam logic [31:0] c_WD1 = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_size, m1_size;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_read, s_wren;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_size;
  logic [31:0] s_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WADDR(32), .WDATA(32), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_size(m0_size), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_size(m1_size), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_read(s_read), .s_wren(s_wren), .s_addr(s_addr), .s_size(s_size),
    .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  // slave returns a tag derived from the read address one cycle later
  always @(posedge clk) s_rdata <= s_read ? (s_addr ^ c_K) : 32'h0;

  typedef struct {
    string       nm;
    logic        rs;
    logic        r0, w0, l0;
    logic [31:0] a0;
    logic        r1, w1, l1;
    logic [31:0] a1;
    logic        eg0, eg1, ev0, ev1;
    logic [31:0] erd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic rs,
                              logic r0, logic w0, logic l0, logic [31:0] a0,
                              logic r1, logic w1, logic l1, logic [31:0] a1,
                              logic eg0, logic eg1, logic ev0, logic ev1, logic [31:0] erd);
    vec_t v;
    v.nm = nm; v.rs = rs;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1;
    v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rs;
    m0_req = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0;
    m1_req = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1;
  endtask

  task automatic check_vec(vec_t v);
    logic [31:0] ea;
    logic [2:0]  ez;
    logic [31:0] ed;
    ea = v.eg0 ? v.a0 : (v.eg1 ? v.a1 : 32'h0);
    ez = v.eg0 ? c_SZ0 : (v.eg1 ? c_SZ1 : 3'd0);
    ed = v.eg0 ? c_WD0 : (v.eg1 ? c_WD1 : 32'h0);
    chk({v.nm, ".m0_gnt"},    {31'd0, m0_gnt},    {31'd0, v.eg0});
    chk({v.nm, ".m1_gnt"},    {31'd0, m1_gnt},    {31'd0, v.eg1});
    chk({v.nm, ".m0_rvalid"}, {31'd0, m0_rvalid}, {31'd0, v.ev0});
    chk({v.nm, ".m1_rvalid"}, {31'd0, m1_rvalid}, {31'd0, v.ev1});
    chk({v.nm, ".s_read"},    {31'd0, s_read},  {31'd0, (v.eg0 & ~v.w0) | (v.eg1 & ~v.w1)});
    chk({v.nm, ".s_wren"},    {31'd0, s_wren},  {31'd0, (v.eg0 & v.w0) | (v.eg1 & v.w1)});
    chk({v.nm, ".s_addr"},    s_addr, ea);
    chk({v.nm, ".s_size"},    {29'd0, s_size}, {29'd0, ez});
    chk({v.nm, ".s_wdata"},   s_wdata, ed);
    if (v.ev0) chk({v.nm, ".m0_rdata"}, m0_rdata, v.erd);
    if (v.ev1) chk({v.nm, ".m1_rdata"}, m1_rdata, v.erd);
  endtask

  initial begin
    int waited;
    bit got;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0;
    m0_size = c_SZ0; m1_size = c_SZ1; m0_wdata = c_WD0; m1_wdata = c_WD1;

    //             name    rs  r0 w0 l0 a0            r1 w1 l1 a1            g0 g1 v0 v1 rdata
    vq.push_back(mk("rst0",  1, 1, 0, 0, 32'h100,     1, 0, 0, 32'h200,     0, 0, 0, 0, 32'h0));
    vq.push_back(mk("rr1",   0, 1, 0, 0, 32'h100,     1, 0, 0, 32'h200,     1, 0, 0, 0, 32'h0));
    vq.push_back(mk("rr2",   0, 1, 0, 0, 32'h100,     1, 0, 0, 32'h200,     0, 1, 1, 0, 32'h100 ^ c_K));
    vq.push_back(mk("rr3",   0, 1, 0, 0, 32'h100,     1, 0, 0, 32'h200,     1, 0, 0, 1, 32'h200 ^ c_K));
    vq.push_back(mk("rr4",   0, 1, 0, 0, 32'h100,     1, 0, 0, 32'h200,     0, 1, 1, 0, 32'h100 ^ c_K));
    vq.push_back(mk("rr5",   0, 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 0, 1, 32'h200 ^ c_K));
    vq.push_back(mk("idle6", 0, 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0));
    vq.push_back(mk("wr7",   0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h10,      0, 1, 0, 0, 32'h0));
    vq.push_back(mk("wr8",   0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h10,      0, 1, 0, 0, 32'h0));
    vq.push_back(mk("wr9",   0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h10,      0, 1, 0, 0, 32'h0));
    vq.push_back(mk("idle10",0, 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0));
    vq.push_back(mk("lk11",  0, 0, 0, 0, 32'h0,       1, 0, 1, 32'h300,     0, 1, 0, 0, 32'h0));
    vq.push_back(mk("lk12",  0, 1, 0, 0, 32'h400,     1, 0, 1, 32'h304,     0, 1, 0, 1, 32'h300 ^ c_K));
    vq.push_back(mk("lk13",  0, 1, 0, 0, 32'h400,     1, 0, 1, 32'h308,     0, 1, 0, 1, 32'h304 ^ c_K));
    vq.push_back(mk("lk14",  0, 1, 0, 0, 32'h400,     1, 0, 0, 32'h30C,     0, 1, 0, 1, 32'h308 ^ c_K));
    vq.push_back(mk("lk15",  0, 1, 0, 0, 32'h400,     0, 0, 0, 32'h0,       1, 0, 0, 1, 32'h30C ^ c_K));
    vq.push_back(mk("lk16",  0, 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 1, 0, 32'h400 ^ c_K));
    vq.push_back(mk("to17",  0, 1, 0, 1, 32'h500,     0, 0, 0, 32'h0,       1, 0, 0, 0, 32'h0));
    vq.push_back(mk("to18",  0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h600,     0, 0, 1, 0, 32'h500 ^ c_K));
    vq.push_back(mk("to19",  0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h600,     0, 0, 0, 0, 32'h0));
    vq.push_back(mk("to20",  0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h600,     0, 0, 0, 0, 32'h0));
    vq.push_back(mk("to21",  0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h600,     0, 0, 0, 0, 32'h0));
    vq.push_back(mk("to22",  0, 0, 0, 0, 32'h0,       1, 1, 0, 32'h600,     0, 1, 0, 0, 32'h0));
    vq.push_back(mk("idle23",0, 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0));
    vq.push_back(mk("mr24",  0, 1, 0, 1, 32'h700,     0, 0, 0, 32'h0,       1, 0, 0, 0, 32'h0));
    vq.push_back(mk("mr25",  1, 1, 0, 0, 32'h704,     1, 0, 0, 32'h804,     0, 0, 0, 0, 32'h0));
    vq.push_back(mk("mr26",  0, 0, 0, 0, 32'h0,       1, 0, 0, 32'h800,     0, 1, 0, 0, 32'h0));
    vq.push_back(mk("mr27",  0, 1, 0, 0, 32'h900,     0, 0, 0, 32'h0,       1, 0, 0, 1, 32'h800 ^ c_K));
    vq.push_back(mk("mr28",  1, 1, 0, 0, 32'h100,     1, 0, 0, 32'h200,     0, 0, 0, 0, 32'h0));
    vq.push_back(mk("mr29",  0, 1, 0, 0, 32'h100,     1, 0, 0, 32'h200,     1, 0, 0, 0, 32'h0));
    vq.push_back(mk("mr30",  0, 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 1, 0, 32'h100 ^ c_K));
    vq.push_back(mk("idle31",0, 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vq[i]);
      #3;
      check_vec(vq[i]);
    end

    // Hand sequence: locked owner goes idle; waiting master is granted on the 5th cycle
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_lock = 1; m0_addr = 32'hA00;
    #3 chk("tseq.lock_gnt", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    m0_req = 0; m0_lock = 0;
    m1_req = 1; m1_we = 1; m1_addr = 32'hB00;
    waited = 0;
    got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      #3;
      if (m1_gnt) begin
        got = 1;
        waited = k;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("tseq.wait_cycles", waited, 32'd5);
    chk("tseq.wren", {31'd0, s_wren}, 32'd1);
    @(posedge clk); #1;
    m1_req = 0; m1_we = 0;
    #3 chk("tseq.idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter for the single-ported unified memory behind the ucoded core. Master 0 is the core's memory port (through its stall wrapper) and master 1 is the host loader/DMA port. It grants at most one access per cycle under round-robin priority, supports locked multi-access sequences, and routes the fixed 1-cycle read data back to the master that issued the read.

## Interface

- Parameters:
- WADDR, 32, address width
- WDATA, 32, data width
- LOCK_TIMEOUT, 16, consecutive owner-idle cycles that force a lock release; 0 disables the timeout
- Ports (x = 0, 1):
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- mx_req  input  1  access request, held until granted
- mx_we  input  1  1 = write, 0 = read
- mx_lock  input  1  keep ownership after this access
- mx_addr  input  WADDR  byte address
- mx_size  input  3  mem_addr_t size/sign code, passed through unchanged
- mx_wdata  input  WDATA  write data
- mx_gnt  output  1  access accepted this cycle
- mx_rvalid  output  1  read data valid (cycle after a granted read)
- mx_rdata  output  WDATA  equals s_rdata, qualified only by mx_rvalid
- s_read, s_wren  output  1  slave read/write strobes
- s_addr  output  WADDR; s_size  output  3; s_wdata  output  WDATA  request fields of the granted master
- s_rdata  input  WDATA  slave read data, valid 1 cycle after s_read

## Operation

- Grant is combinational: mx_gnt is 1 in the same cycle as the mx_req it accepts. The slave always accepts, so every grant is one transfer.
- Slave mux: when mx_gnt=1, s_read = !mx_we, s_wren = mx_we, and s_addr/s_size/s_wdata come from master x. With no grant, s_read = s_wren = 0 and s_addr/s_size/s_wdata = 0.
- Arbitration states:
  - UNLOCKED: if exactly one master requests, grant it. If both request, grant the master that was not granted last (the last-grant pointer `last`).
  - LOCKEDx: only master x may be granted. The other master's request is held off with no grant.
- Transitions, evaluated on a granted cycle of master x:
  - mx_lock=1 → LOCKEDx.
  - mx_lock=0 → UNLOCKED.
  - The lock can be entered from UNLOCKED and re-armed from LOCKEDx.
- Lock timeout: in LOCKEDx, a counter increments on every cycle with mx_req=0 and clears on any cycle with mx_req=1. When LOCK_TIMEOUT≠0 and the counter reaches LOCK_TIMEOUT, the state returns to UNLOCKED and the counter clears. Arbitration then proceeds normally from the next cycle.
- `last` updates to x on every grant to x.
- Read return: register rd_pend = (granted read) and rd_owner = x. On the next cycle, mx_rvalid = rd_pend & (rd_owner == x). A granted write produces no rvalid.
- A new grant may coincide with the rvalid of the previous read, giving back-to-back reads at full throughput.
- Reset values: state UNLOCKED, last = 1 (master 0 wins the first tie), timeout counter 0, rd_pend 0. Consequently all gnt, rvalid, s_read and s_wren are 0 during and immediately after reset.
- Reset mid-operation: any pending rvalid is dropped, and any lock is released.

## Timing

- Grant latency: 0 cycles when the request is eligible.
- Read data latency: 1 cycle after the grant.
- Worst-case wait, unlocked: 1 cycle.
- Worst-case wait, locked: until the owner issues an unlocked access, or until LOCK_TIMEOUT idle cycles plus 1.
- Combinational paths: mx_req/mx_we/fields → mx_gnt/s_*, and s_rdata → mx_rdata. All other outputs are registered.
- Throughput: one transfer per cycle.

## Test plan

- Reset then both masters request reads (m0 0x100, m1 0x200) and keep requesting → grants alternate m0, m1, m0, m1. m0_rvalid is high in cycles 2 and 4, m1_rvalid in cycles 3 and 5, each carrying the s_rdata of its own address.
- Single master m1 issues writes 0x10→0xDEAD_BEEF for 3 cycles with m0 idle → m1_gnt high every cycle, s_wren=1, s_size passed through, no rvalid on either port.
- m1 granted with lock=1, then m0 requests continuously while m1 issues 2 more locked accesses and a final lock=0 access → m0_gnt stays low for those 4 cycles and rises in the cycle after the lock=0 grant.
- LOCK_TIMEOUT=4: m0 locks, then drops req while m1 requests → m1 is held off for exactly 4 cycles and granted in the 5th.
- Read granted to m0, rst asserted in the next cycle → m0_rvalid stays 0, the lock (if any) is cleared, and after reset the first tie is won by m0.
